// File: rtl/mmu_axi4_master.sv
// MMU request port to single-beat AXI4 master bridge.
// Optional posted writes: define MMU_AXI_POSTED_WR_EN.
`timescale 1ns/1ps
module mmu_axi4_master #(
  parameter int         AXI_ADDR_WIDTH = 16,
  parameter int         AXI_DATA_WIDTH = 16,
  parameter logic [2:0] AXI_PROT       = 3'b000
) (
  input  logic                      m_aclk,
  input  logic                      m_aresetn,
  input  logic                      mmu_wt_en,
  input  logic                      mmu_rd_en,
  input  logic [AXI_ADDR_WIDTH-1:0] mmu_wt_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] mmu_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] mmu_wt_data,
  output logic [AXI_DATA_WIDTH-1:0] mmu_rd_data,
  output logic                      mmu_ready,
  output logic                      mmu_valid,
  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      s_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_wdata,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      s_wready,
  input  logic                      s_bvalid,
  output logic                      m_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      s_arready,
  input  logic [AXI_DATA_WIDTH-1:0] s_rdata,
  input  logic                      s_rvalid,
  output logic                      m_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic aw_done_q, w_done_q, rd_pend_q;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_fin, accept, wr_blk;

  assign m_awlen  = 8'd0;
  assign m_arlen  = 8'd0;
  assign m_awsize = 3'b001;
  assign m_arsize = 3'b001;
  assign m_awprot = AXI_PROT;
  assign m_arprot = AXI_PROT;

  assign m_awvalid = (state_q == WR_REQ) & ~aw_done_q;
  assign m_wvalid  = (state_q == WR_REQ) & ~w_done_q;
  assign m_wlast   = m_wvalid;
  assign m_arvalid = (state_q == RD_ADDR);
  assign m_rready  = (state_q == RD_DATA);
  assign mmu_valid = (state_q == DONE);

  assign aw_hs = m_awvalid & s_awready;
  assign w_hs  = m_wvalid & s_wready;
  assign b_hs  = m_bready & s_bvalid;
  assign ar_hs = m_arvalid & s_arready;
  assign r_hs  = m_rready & s_rvalid;

  assign wr_fin = (aw_done_q | aw_hs) & (w_done_q | w_hs);

`ifdef MMU_AXI_POSTED_WR_EN
  logic b_pend_q;
  logic bready_q;

  // only one B may be in flight, so a new write waits for it
  assign wr_blk   = b_pend_q & mmu_wt_en;
  assign m_bready = bready_q;

  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      b_pend_q <= 1'b0;
      bready_q <= 1'b0;
    end else begin
      bready_q <= 1'b1;
      if (state_q == WR_REQ && wr_fin)
        b_pend_q <= 1'b1;
      else if (b_hs)
        b_pend_q <= 1'b0;
    end
  end
`else
  assign wr_blk   = 1'b0;
  assign m_bready = (state_q == WR_RESP);
`endif

  assign mmu_ready = (state_q == IDLE) & ~wr_blk;
  assign accept    = mmu_ready & (mmu_wt_en | mmu_rd_en);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept)
          state_d = mmu_wt_en ? WR_REQ : RD_ADDR;
      WR_REQ:
        if (wr_fin) begin
`ifdef MMU_AXI_POSTED_WR_EN
          state_d = rd_pend_q ? RD_ADDR : DONE;
`else
          state_d = WR_RESP;
`endif
        end
      WR_RESP:
        if (b_hs)
          state_d = rd_pend_q ? RD_ADDR : DONE;
      RD_ADDR:
        if (ar_hs)
          state_d = RD_DATA;
      RD_DATA:
        if (r_hs)
          state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      m_awaddr    <= '0;
      m_araddr    <= '0;
      m_wdata     <= '0;
      mmu_rd_data <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      if (accept) begin
        m_awaddr  <= mmu_wt_addr;
        m_araddr  <= mmu_rd_addr;
        m_wdata   <= mmu_wt_data;
        rd_pend_q <= mmu_wt_en & mmu_rd_en;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs)
        aw_done_q <= 1'b1;
      if (w_hs)
        w_done_q <= 1'b1;
      if (r_hs)
        mmu_rd_data <= s_rdata;
      if (state_q == DONE)
        rd_pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmu_axi4_master.sv
// Bench for mmu_axi4_master: AXI slave model with
// per-channel wait states and a latency scoreboard.
`timescale 1ns/1ps
module tb_mmu_axi4_master;

`ifdef MMU_AXI_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  localparam logic [2:0] PROT = 3'b010;

  logic        m_aclk = 1'b0;
  logic        m_aresetn;
  logic        mmu_wt_en, mmu_rd_en;
  logic [15:0] mmu_wt_addr, mmu_rd_addr, mmu_wt_data;
  logic [15:0] mmu_rd_data;
  logic        mmu_ready, mmu_valid;
  logic [15:0] m_awaddr, m_araddr, m_wdata, s_rdata;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
  logic        m_awvalid, m_wvalid, m_wlast, m_bready;
  logic        m_arvalid, m_rready;
  logic        s_awready, s_wready, s_bvalid;
  logic        s_arready, s_rvalid;

  mmu_axi4_master #(
    .AXI_ADDR_WIDTH(16),
    .AXI_DATA_WIDTH(16),
    .AXI_PROT(PROT)
  ) dut (
    .m_aclk(m_aclk),
    .m_aresetn(m_aresetn),
    .mmu_wt_en(mmu_wt_en),
    .mmu_rd_en(mmu_rd_en),
    .mmu_wt_addr(mmu_wt_addr),
    .mmu_rd_addr(mmu_rd_addr),
    .mmu_wt_data(mmu_wt_data),
    .mmu_rd_data(mmu_rd_data),
    .mmu_ready(mmu_ready),
    .mmu_valid(mmu_valid),
    .m_awaddr(m_awaddr),
    .m_awlen(m_awlen),
    .m_awsize(m_awsize),
    .m_awprot(m_awprot),
    .m_awvalid(m_awvalid),
    .s_awready(s_awready),
    .m_wdata(m_wdata),
    .m_wlast(m_wlast),
    .m_wvalid(m_wvalid),
    .s_wready(s_wready),
    .s_bvalid(s_bvalid),
    .m_bready(m_bready),
    .m_araddr(m_araddr),
    .m_arlen(m_arlen),
    .m_arsize(m_arsize),
    .m_arprot(m_arprot),
    .m_arvalid(m_arvalid),
    .s_arready(s_arready),
    .s_rdata(s_rdata),
    .s_rvalid(s_rvalid),
    .m_rready(m_rready)
  );

  always #5 m_aclk = ~m_aclk;

  int aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_dly = 0, r_dly = 0;

  logic [15:0] mem [0:255];
  logic        aw_got, w_got, b_act, r_act;
  logic [15:0] sl_awaddr, sl_wdata, sl_raddr;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        aw_have, w_have, wr_fire;
  logic [15:0] wa, wd;

  assign s_awready = m_awvalid && (aw_cnt >= aw_dly);
  assign s_wready  = m_wvalid && (w_cnt >= w_dly);
  assign s_arready = m_arvalid && (ar_cnt >= ar_dly);
  assign s_bvalid  = b_act && (b_cnt >= b_dly);
  assign s_rvalid  = r_act && (r_cnt >= r_dly);
  assign s_rdata   = s_rvalid ? mem[sl_raddr[7:0]] : 16'h0;

  assign aw_hs = m_awvalid && s_awready;
  assign w_hs  = m_wvalid && s_wready;
  assign b_hs  = s_bvalid && m_bready;
  assign ar_hs = m_arvalid && s_arready;
  assign r_hs  = s_rvalid && m_rready;

  assign aw_have = aw_got || aw_hs;
  assign w_have  = w_got || w_hs;
  assign wa      = aw_got ? sl_awaddr : m_awaddr;
  assign wd      = w_got ? sl_wdata : m_wdata;
  assign wr_fire = aw_have && w_have && !b_act;

  always_ff @(posedge m_aclk)
    if (m_aresetn && wr_fire)
      mem[wa[7:0]] <= wd;

  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      aw_got <= 1'b0; w_got <= 1'b0;
      b_act <= 1'b0; r_act <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      b_cnt <= 0; r_cnt <= 0;
      sl_awaddr <= '0; sl_wdata <= '0;
      sl_raddr <= '0;
    end else begin
      aw_cnt <= (m_awvalid && !s_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid && !s_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_arvalid && !s_arready) ? ar_cnt + 1 : 0;
      if (aw_hs) begin
        aw_got <= 1'b1; sl_awaddr <= m_awaddr;
      end
      if (w_hs) begin
        w_got <= 1'b1; sl_wdata <= m_wdata;
      end
      if (wr_fire) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        b_act <= 1'b1; b_cnt <= 0;
      end else if (b_act) begin
        if (b_hs) b_act <= 1'b0;
        else      b_cnt <= b_cnt + 1;
      end
      if (ar_hs) begin
        r_act <= 1'b1; r_cnt <= 0;
        sl_raddr <= m_araddr;
      end else if (r_act) begin
        if (r_hs) r_act <= 1'b0;
        else      r_cnt <= r_cnt + 1;
      end
    end
  end

  int          cyc = 0;
  int          b_cyc = 0, ar_cyc = 0;
  logic [15:0] lg_awaddr = '0, lg_wdata = '0, lg_araddr = '0;
  logic [7:0]  lg_awlen = '0, lg_arlen = '0;
  logic [2:0]  lg_awsize = '0, lg_arsize = '0;
  logic [2:0]  lg_awprot = '0, lg_arprot = '0;
  logic        lg_wlast = 1'b0;

  always_ff @(posedge m_aclk) begin
    cyc <= cyc + 1;
    if (aw_hs) begin
      lg_awaddr <= m_awaddr; lg_awlen <= m_awlen;
      lg_awsize <= m_awsize; lg_awprot <= m_awprot;
    end
    if (w_hs) begin
      lg_wdata <= m_wdata; lg_wlast <= m_wlast;
    end
    if (b_hs) b_cyc <= cyc;
    if (ar_hs) begin
      ar_cyc <= cyc; lg_araddr <= m_araddr;
      lg_arlen <= m_arlen; lg_arsize <= m_arsize;
      lg_arprot <= m_arprot;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // request cycle, AW/W phase, optional B phase, DONE
  function automatic int wr_part(input int aw, input int w,
                                 input int b);
    return (mx(aw, w) + 1) + (POSTED ? 0 : b + 1);
  endfunction

  function automatic int wr_lat(input int aw, input int w,
                                input int b);
    return 1 + wr_part(aw, w, b) + 1;
  endfunction

  function automatic int rd_lat(input int ar, input int r);
    return 1 + (ar + 1) + (r + 1) + 1;
  endfunction

  task automatic req(input string tag,
                     input bit wt, input bit rd,
                     input logic [15:0] wa_i,
                     input logic [15:0] ra_i,
                     input logic [15:0] wd_i,
                     input int lat,
                     input logic [15:0] exp_rd,
                     output int waits, output int busy_rdy,
                     output int awv_n, output int wv_n,
                     output int bad_br);
    exp_t e;
    int   n;
    e.rd = exp_rd;
    e.lat = lat;
    sb.push_back(e);
    waits = 0; busy_rdy = 0;
    awv_n = 0; wv_n = 0; bad_br = 0;
    @(negedge m_aclk);
    mmu_wt_en = wt; mmu_rd_en = rd;
    mmu_wt_addr = wa_i; mmu_rd_addr = ra_i;
    mmu_wt_data = wd_i;
    #1;
    while (!mmu_ready && waits < 50) begin
      @(negedge m_aclk); #1;
      waits++;
    end
    if (!mmu_ready) begin
      check({tag, "_accept_timeout"}, 0, 1);
      mmu_wt_en = 1'b0; mmu_rd_en = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge m_aclk); #1;
    mmu_wt_en = 1'b0; mmu_rd_en = 1'b0;
    n = 1;
    while (n < 100) begin
      @(negedge m_aclk);
      n++;
      if (mmu_ready) busy_rdy++;
      if (m_awvalid) awv_n++;
      if (m_wvalid) wv_n++;
      if (m_bready && (m_awvalid || m_wvalid)) bad_br++;
      if (mmu_valid) break;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_rd_data"}, mmu_rd_data, e.rd);
  endtask

  int wt, br, av, wv, bb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    m_aresetn = 1'b0;
    mmu_wt_en = 1'b0; mmu_rd_en = 1'b0;
    mmu_wt_addr = '0; mmu_rd_addr = '0;
    mmu_wt_data = '0;
    repeat (3) @(negedge m_aclk);
    check("rst_valids", {m_awvalid, m_wvalid, m_bready,
          m_arvalid, m_rready, mmu_valid}, 0);
    check("rst_ready", mmu_ready, 1);
    check("rst_data", {mmu_rd_data, m_awaddr,
          m_araddr, m_wdata}, 0);
    m_aresetn = 1'b1;

    // zero-wait write
    req("wr_beef", 1, 0, 16'h0010, 16'h0, 16'hBEEF,
        wr_lat(0, 0, 0), 16'h0, wt, br, av, wv, bb);
    check("wr_awaddr", lg_awaddr, 16'h0010);
    check("wr_wdata", lg_wdata, 16'hBEEF);
    check("wr_awlen", lg_awlen, 0);
    check("wr_awsize", lg_awsize, 3'b001);
    check("wr_awprot", lg_awprot, PROT);
    check("wr_wlast", lg_wlast, 1);
    @(negedge m_aclk);
    check("wr_valid_pulse", mmu_valid, 0);
    check("wr_ready_back", mmu_ready, 1);

    // read with slow rvalid
    r_dly = 3;
    req("rd_beef", 0, 1, 16'h0, 16'h0010, 16'h0,
        rd_lat(0, 3), 16'hBEEF, wt, br, av, wv, bb);
    check("rd_busy_ready", br, 0);
    check("rd_araddr", lg_araddr, 16'h0010);
    check("rd_arlen_size", {lg_arlen, lg_arsize},
          {8'd0, 3'b001});
    check("rd_arprot", lg_arprot, PROT);
    r_dly = 0;

    // simultaneous write then read
    req("wr_rd", 1, 1, 16'h0020, 16'h0020, 16'h1234,
        1 + wr_part(0, 0, 0) + rd_lat(0, 0) - 1,
        16'h1234, wt, br, av, wv, bb);
`ifndef MMU_AXI_POSTED_WR_EN
    check("wr_rd_b_before_ar", b_cyc < ar_cyc, 1);
`endif

    // AW ready two cycles late
    aw_dly = 2;
    req("aw_slow", 1, 0, 16'h0040, 16'h0, 16'h5555,
        wr_lat(2, 0, 0), 16'h1234, wt, br, av, wv, bb);
    check("aw_slow_awv_cycles", av, 3);
    check("aw_slow_wv_cycles", wv, 1);
`ifndef MMU_AXI_POSTED_WR_EN
    check("aw_slow_bready_early", bb, 0);
`endif
    aw_dly = 0;

    // reset while waiting on read data
    r_dly = 10;
    @(negedge m_aclk);
    mmu_rd_en = 1'b1; mmu_rd_addr = 16'h0010;
    @(posedge m_aclk); #1;
    mmu_rd_en = 1'b0;
    for (int i = 0; i < 20 && !m_rready; i++)
      @(negedge m_aclk);
    check("rst_mid_in_rd_data", m_rready, 1);
    m_aresetn = 1'b0;
    #1;
    check("rst_mid_valids", {m_awvalid, m_wvalid,
          m_bready, m_arvalid, m_rready, mmu_valid}, 0);
    check("rst_mid_ready", mmu_ready, 1);
    check("rst_mid_data", {mmu_rd_data, m_awaddr,
          m_araddr, m_wdata}, 0);
    @(negedge m_aclk);
    m_aresetn = 1'b1;
    r_dly = 0;
    req("post_rst_wr", 1, 0, 16'h0030, 16'h0, 16'hCAFE,
        wr_lat(0, 0, 0), 16'h0, wt, br, av, wv, bb);
    req("post_rst_rd", 0, 1, 16'h0, 16'h0030, 16'h0,
        rd_lat(0, 0), 16'hCAFE, wt, br, av, wv, bb);

`ifdef MMU_AXI_POSTED_WR_EN
    // slow B: a second write stalls, a read does not
    b_dly = 5;
    req("pw_first", 1, 0, 16'h0050, 16'h0, 16'h1111,
        wr_lat(0, 0, 5), 16'hCAFE, wt, br, av, wv, bb);
    check("pw_first_waits", wt, 0);
    req("pw_second", 1, 0, 16'h0052, 16'h0, 16'h2222,
        wr_lat(0, 0, 5), 16'hCAFE, wt, br, av, wv, bb);
    check("pw_second_waits", wt, 5);
    req("pw_read_gap", 0, 1, 16'h0, 16'h0052, 16'h0,
        rd_lat(0, 0), 16'h2222, wt, br, av, wv, bb);
    check("pw_read_gap_waits", wt, 0);
    b_dly = 0;
`endif

    repeat (10) @(negedge m_aclk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_axi4_master.md
Name: mmu_axi4_master

Overview:
- Bridges the blitter's MMU request port (intf_mmu slave side) onto an AMBA AXI4 master port (intf_axi4 master side).
- Converts each MMU read/write request into a single-beat AXI4 transaction, then returns read data and completion via mmu_ready/mmu_valid.
- Sits directly upstream of the AXI4 interconnect/memory slave and downstream of the blitter engine.

Parameters:
- AXI_ADDR_WIDTH, 16, address width of MMU and AXI ports.
- AXI_DATA_WIDTH, 16, data width; must be 16 (awsize/arsize fixed to 2 bytes).
- AXI_PROT, 3'b000, constant driven on m_awprot and m_arprot.

Ports:
- m_aclk  in  1  single clock, all logic rising-edge.
- m_aresetn  in  1  asynchronous active-low reset.
- mmu_wt_en / mmu_rd_en  in  1 each  write / read request.
- mmu_wt_addr / mmu_rd_addr / mmu_wt_data  in  16 each  request address / write data.
- mmu_rd_data  out  16  read result.
- mmu_ready  out  1  bridge idle, request accepted this cycle.
- mmu_valid  out  1  one-cycle completion pulse.
- m_awaddr / m_araddr  out  16  registered transaction addresses.
- m_awlen / m_arlen  out  8  constant 8'd0.
- m_awsize / m_arsize  out  3  constant 3'b001.
- m_awprot / m_arprot  out  3  AXI_PROT.
- m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready  out  1  AXI handshakes.
- m_wdata  out  16  registered write data.
- m_wlast  out  1  equals m_wvalid.
- s_awready, s_wready, s_bvalid, s_arready, s_rvalid  in  1  slave handshakes.
- s_rdata  in  16  read data.

Behaviour:
- Reset (async, m_aresetn=0): FSM to IDLE; all valid/ready outputs to 0; mmu_ready=1; mmu_rd_data, m_awaddr, m_araddr and m_wdata to 0; pending-read flag to 0. Reset mid-transaction abandons it silently.
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: mmu_ready=1. On rising edge with mmu_wt_en|mmu_rd_en, latch all addresses and data, then drop mmu_ready.
  - wt_en → WR_REQ.
  - rd_en only → RD_ADDR.
  - Both set: write first, set pending-read flag, then perform the read (read observes written data).
- WR_REQ: assert m_awvalid and m_wvalid together; each deasserts independently on its own handshake (valid&ready). Go to WR_RESP when both have completed (same or different cycles).
- WR_RESP: m_bready=1. On s_bvalid, go to RD_ADDR if pending-read, else DONE.
- RD_ADDR: m_arvalid=1 until s_arready, then RD_DATA.
- RD_DATA: m_rready=1. On s_rvalid, capture s_rdata into mmu_rd_data and go to DONE.
- DONE: mmu_valid=1 for exactly one cycle, mmu_ready=0, clear pending-read, return to IDLE.
- mmu_rd_data holds its value until the next read completes; writes do not alter it.
- Valid signals never drop before their handshake; no combinational path from s_* to m_*valid.
- Latency, zero-wait slave:
  - Write: request → mmu_valid = 4 cycles.
  - Read: request → mmu_valid = 4 cycles.
  - Combined write+read: 6 cycles.
- Requests arriving while mmu_ready=0 are ignored; the master must hold them.

Optional Feature:
- Macro MMU_AXI_POSTED_WR_EN.
- Defined: a write completes to the MMU (DONE) once AW and W handshakes finish. m_bready stays 1 and a background flag tracks one outstanding B.
  - mmu_ready stays 0 for a new write until the B is received.
  - Reads may issue while the B is outstanding.
  - Write-only latency drops to 3 cycles.
- Undefined: WR_RESP is mandatory as described above.

Test Plan:
- Write 0xBEEF to 0x0010, zero-wait slave:
  - AW/W carry 0x0010/0xBEEF, awlen=0, awsize=1, wlast=1.
  - mmu_valid pulses 4 cycles after the request; mmu_ready returns high.
- Read 0x0010 with slave returning 0xBEEF after 3 rvalid wait cycles → mmu_rd_data=0xBEEF when mmu_valid pulses; mmu_ready=0 throughout.
- Simultaneous wt_en (0x0020←0x1234) and rd_en (0x0020):
  - Write B precedes AR.
  - Single mmu_valid pulse with mmu_rd_data=0x1234.
- s_awready delayed 2 cycles, s_wready immediate → m_wvalid drops after 1 cycle, m_awvalid held 3 cycles, m_bready only after both handshakes.
- Assert m_aresetn=0 during RD_DATA → all outputs at reset values immediately; next read to 0x0030 completes normally.
- With MMU_AXI_POSTED_WR_EN:
  - Write, then immediate second write with s_bvalid delayed 5 cycles → second request not accepted until B arrives.
  - A read issued in the same gap is accepted.
